// File: rtl/ex_arbiter_if.sv
// Host-facing exception record channel: valid/ready record transfer plus the resume pulse.
interface ex_arbiter_if;
    logic        host_ex_valid;
    logic        host_ex_ready;
    logic [15:0] host_ex_data;
    logic        host_resume;

    modport master (
        output host_ex_valid,
        output host_ex_data,
        input  host_ex_ready,
        input  host_resume
    );

    modport slave (
        input  host_ex_valid,
        input  host_ex_data,
        output host_ex_ready,
        output host_resume
    );
endinterface

// File: rtl/ex_arbiter.sv
// Round-robin selection of one stalled thread at a time; presents its record to the host,
// waits for the resume decision and pulses clr_ex back to that thread's status register.
module ex_arbiter #(
    parameter int NUM_THR = 4,
    parameter int PTR_W   = $clog2(NUM_THR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_THR-1:0]   thr_stall,
    input  logic [6*NUM_THR-1:0] thr_ex_cause,
    input  logic [8*NUM_THR-1:0] thr_id,
    ex_arbiter_if.master         host,
    output logic [NUM_THR-1:0]   clr_ex,
    output logic                 busy,
    output logic [7:0]           ex_count
);
    localparam int unsigned NT = NUM_THR;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        WAIT_RESUME,
        CLEAR
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_idx;
    logic [5:0]         r_cause;
    logic [7:0]         r_id;
    logic               r_valid;
    logic [NUM_THR-1:0] r_clr;
    logic [7:0]         r_count;

    logic               w_any;
    logic [PTR_W-1:0]   w_sel;
    logic [5:0]         w_cause;
    logic [7:0]         w_id;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [NUM_THR-1:0] w_idx_oh;

    // Circular first-set search starting at the round-robin pointer.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        w_any   = 1'b0;
        w_sel   = '0;
        w_cause = '0;
        w_id    = '0;
        for (int unsigned i = 0; i < NT; i++) begin
            cand = 32'(r_rr_ptr) + i;
            if (cand >= NT) begin
                cand = cand - NT;
            end
            if (!w_any && thr_stall[PTR_W'(cand)]) begin
                w_any   = 1'b1;
                w_sel   = PTR_W'(cand);
                w_cause = thr_ex_cause[6*cand +: 6];
                w_id    = thr_id[8*cand +: 8];
            end
        end
    end

    assign w_next_ptr = (w_sel == PTR_W'(NT - 1)) ? '0 : w_sel + PTR_W'(1);
    assign w_idx_oh   = {{(NUM_THR-1){1'b0}}, 1'b1} << r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_idx    <= '0;
            r_cause  <= '0;
            r_id     <= '0;
            r_valid  <= 1'b0;
            r_clr    <= '0;
            r_count  <= '0;
        end else begin
            r_clr <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx    <= w_sel;
                        r_cause  <= w_cause;
                        r_id     <= w_id;
                        r_valid  <= 1'b1;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (host.host_ex_ready) begin
                        r_valid <= 1'b0;
                        if (r_count != '1) begin
                            r_count <= r_count + 8'd1;
                        end
                        r_state <= WAIT_RESUME;
                    end
                end
                WAIT_RESUME: begin
                    // Resume wins over a simultaneous self-clear so the clear is still issued.
                    if (host.host_resume) begin
                        r_clr   <= w_idx_oh;
                        r_state <= CLEAR;
                    end else if (!thr_stall[r_idx]) begin
                        r_state <= IDLE;
                    end
                end
                CLEAR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign host.host_ex_valid = r_valid;
    assign host.host_ex_data  = {2'b00, r_id, r_cause};
    assign clr_ex             = r_clr;
    assign ex_count           = r_count;
    assign busy               = (r_state != IDLE);

endmodule

// File: tb/tb_ex_arbiter.sv
// Randomised and directed episodes against a set-based round-robin model; a negedge monitor
// pops expected records and clears from queues filled by the stimulus.
module tb_ex_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   thr_stall;
    logic [6*N-1:0] thr_ex_cause;
    logic [8*N-1:0] thr_id;
    logic [N-1:0]   clr_ex;
    logic           busy;
    logic [7:0]     ex_count;

    ex_arbiter_if hif();

    ex_arbiter #(.NUM_THR(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .thr_stall    (thr_stall),
        .thr_ex_cause (thr_ex_cause),
        .thr_id       (thr_id),
        .host         (hif),
        .clr_ex       (clr_ex),
        .busy         (busy),
        .ex_count     (ex_count)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [15:0]  exp_data_q[$];
    logic [N-1:0] exp_clr_q[$];
    int           mon_hs   = 0;
    int           ptr      = 0;
    bit           pend[N];
    int           hs_total = 0;
    logic [N-1:0] refault_pending = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Status registers: a clear seen during a cycle drops the stall on the following edge.
    task automatic tick();
        logic [N-1:0] c;
        @(negedge clk);
        c = clr_ex;
        @(posedge clk);
        #1;
        thr_stall       = (thr_stall & ~c) | (c & refault_pending);
        refault_pending = refault_pending & ~c;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_valid();
        for (int k = 0; k < 20; k++) begin
            if (hif.host_ex_valid === 1'b1) return;
            tick();
        end
        check("valid_timeout", 32'(hif.host_ex_valid), 32'd1);
        finish_run();
    endtask

    task automatic run_episode(input logic [N-1:0] mask, input int bp_fixed, input logic [N-1:0] selfclr,
                               input logic [N-1:0] refault, input bit early, input bit rnd);
        int           w;
        bit           first;
        logic [N-1:0] used_ref;
        first    = 1'b1;
        used_ref = '0;
        for (int t = 0; t < N; t++) pend[t] = mask[t];
        thr_stall         = mask;
        hif.host_ex_ready = early;
        while (pick() >= 0) begin
            w   = pick();
            ptr = (w + 1) % N;
            exp_data_q.push_back({2'b00, thr_id[w*8 +: 8], thr_ex_cause[w*6 +: 6]});
            if (rnd && !first) hif.host_ex_ready = 1'($urandom_range(0, 1));
            if (first) begin
                tick();
                check("latency_valid", 32'(hif.host_ex_valid), 32'd1);
                first = 1'b0;
            end
            wait_valid();
            if (hif.host_ex_ready !== 1'b1) begin
                repeat (rnd ? $urandom_range(0, 4) : bp_fixed) begin
                    thr_ex_cause[w*6 +: 6] = 6'($urandom);
                    thr_id[w*8 +: 8]       = 8'($urandom);
                    tick();
                    check("valid_held", 32'(hif.host_ex_valid), 32'd1);
                end
                hif.host_ex_ready = 1'b1;
            end
            tick();
            hif.host_ex_ready = 1'b0;
            hs_total++;
            check("valid_drop", 32'(hif.host_ex_valid), 32'd0);
            if (rnd) repeat ($urandom_range(0, 2)) tick();
            if (selfclr[w]) begin
                thr_stall[w] = 1'b0;
                pend[w]      = 1'b0;
                tick();
            end else begin
                exp_clr_q.push_back(N'(1) << w);
                if (refault[w] && !used_ref[w]) begin
                    used_ref[w]        = 1'b1;
                    refault_pending[w] = 1'b1;
                end else begin
                    pend[w] = 1'b0;
                end
                hif.host_resume = 1'b1;
                tick();
                hif.host_resume = 1'b0;
            end
        end
        repeat (3) tick();
        check("idle_after_episode", 32'({hif.host_ex_valid, busy}), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon_hs = 0;
            exp_data_q.delete();
            exp_clr_q.delete();
        end else begin
            if (hif.host_ex_valid === 1'b1 && hif.host_ex_ready === 1'b1) begin
                if (exp_data_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL record_unexpected: got %h, required no record", hif.host_ex_data);
                end else begin
                    check("record", 32'(hif.host_ex_data), 32'(exp_data_q.pop_front()));
                end
                check("ex_count_at_hs", 32'(ex_count), (mon_hs > 255) ? 32'd255 : 32'(mon_hs));
                mon_hs++;
            end
            if (clr_ex !== '0) begin
                if (exp_clr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL clr_unexpected: got %b, required 0", clr_ex);
                end else begin
                    check("clr_ex", 32'(clr_ex), 32'(exp_clr_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst               = 1'b1;
        thr_stall         = '0;
        thr_ex_cause      = '0;
        thr_id            = '0;
        hif.host_ex_ready = 1'b0;
        hif.host_resume   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", 32'(hif.host_ex_valid), 32'd0);
        check("rst_data", 32'(hif.host_ex_data), 32'd0);
        check("rst_clr", 32'(clr_ex), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(ex_count), 32'd0);

        repeat (10) begin
            tick();
            check("idle_valid", 32'(hif.host_ex_valid), 32'd0);
            check("idle_count", 32'(ex_count), 32'd0);
        end

        thr_id       = {8'h13, 8'h02, 8'h11, 8'h10};
        thr_ex_cause = {6'h2A, 6'h05, 6'h1C, 6'h31};
        run_episode(4'b0100, 0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        check("single_count", 32'(ex_count), 32'd1);
        run_episode(4'b0010, 5, 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_episode(4'b1000, 0, 4'b1000, 4'b0000, 1'b0, 1'b0);
        run_episode(4'b1011, 0, 4'b0000, 4'b0001, 1'b1, 1'b0);

        // Reset while waiting for resume abandons the record and must not issue a clear.
        thr_stall[1] = 1'b1;
        pend[1]      = 1'b1;
        w_push_mid: begin
            exp_data_q.push_back({2'b00, thr_id[15:8], thr_ex_cause[11:6]});
            ptr = (pick() + 1) % N;
        end
        hif.host_ex_ready = 1'b1;
        wait_valid();
        tick();
        hif.host_ex_ready = 1'b0;
        check("busy_wait_resume", 32'(busy), 32'd1);
        rst       = 1'b1;
        thr_stall = '0;
        for (int t = 0; t < N; t++) pend[t] = 1'b0;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(hif.host_ex_valid), 32'd0);
        check("midrst_data", 32'(hif.host_ex_data), 32'd0);
        check("midrst_clr", 32'(clr_ex), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(ex_count), 32'd0);
        ptr             = 0;
        hs_total        = 0;
        refault_pending = '0;
        repeat (3) tick();

        for (int ep = 0; ep < 400 && hs_total < 300; ep++) begin
            logic [N-1:0] m;
            logic [N-1:0] sc;
            logic [N-1:0] rf;
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int t = 0; t < N; t++) begin
                sc[t]                  = ($urandom_range(0, 5) == 0);
                rf[t]                  = ($urandom_range(0, 3) == 0);
                thr_ex_cause[t*6 +: 6] = 6'($urandom);
                thr_id[t*8 +: 8]       = 8'($urandom);
            end
            run_episode(m, 0, sc, rf, 1'($urandom_range(0, 1)), 1'b1);
        end

        check("ex_count_sat", 32'(ex_count), (hs_total >= 255) ? 32'd255 : 32'(hs_total));
        check("hs_reached_300", 32'(hs_total >= 300), 32'd1);
        check("records_drained", 32'(exp_data_q.size()), 32'd0);
        check("clears_drained", 32'(exp_clr_q.size()), 32'd0);
        finish_run();
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1);
    end
endmodule
